// File: rtl/spram_arb_pkg.sv
// Shared constants for the two-master single-port SRAM arbiter.
package spram_arb_pkg;

   localparam logic ARB_M0    = 1'b0;
   localparam logic ARB_M1    = 1'b1;
   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   localparam int unsigned ARB_ADDR_W = 14;
   localparam int unsigned ARB_DATA_W = 32;
   localparam int unsigned ARB_CNT_W  = 8;

   localparam logic [3:0] ARB_WENB_IDLE = 4'hF;

endpackage

// File: rtl/spram_arb_pick.sv
// Combinational winner select: one-hot grant from the two valids and arbitration state.
module spram_arb_pick
   import spram_arb_pkg::*;
(
   input  logic [1:0] valid_i,
   input  logic       mode_i,
   input  logic       last_grant_i,
   input  logic       starve_hit_i,
   output logic [1:0] grant_c
);

   always_comb begin
      grant_c = 2'b00;
      unique case (valid_i)
         2'b01:   grant_c = 2'b01;
         2'b10:   grant_c = 2'b10;
         2'b11: begin
            if (mode_i == ARB_RR) begin
               grant_c = (last_grant_i == ARB_M0) ? 2'b10 : 2'b01;
            end else begin
               grant_c = starve_hit_i ? 2'b10 : 2'b01;
            end
         end
         default: grant_c = 2'b00;
      endcase
   end

endmodule

// File: rtl/spram_arbiter.sv
// Two-master arbiter in front of a single-port SRAM with 1-cycle read return.
module spram_arbiter
   import spram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ARB_ADDR_W,
   parameter int unsigned DATA_W       = ARB_DATA_W,
   parameter int unsigned ARB_MODE     = 0,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  m0_valid_i,
   output logic                  m0_ready_o,
   input  logic [ADDR_W-1:0]     m0_addr_i,
   input  logic [DATA_W/8-1:0]   m0_wstrb_i,
   input  logic [DATA_W-1:0]     m0_wdata_i,
   output logic                  m0_rvalid_o,
   output logic [DATA_W-1:0]     m0_rdata_o,
   input  logic                  m1_valid_i,
   output logic                  m1_ready_o,
   input  logic [ADDR_W-1:0]     m1_addr_i,
   input  logic [DATA_W/8-1:0]   m1_wstrb_i,
   input  logic [DATA_W-1:0]     m1_wdata_i,
   output logic                  m1_rvalid_o,
   output logic [DATA_W-1:0]     m1_rdata_o,
   output logic [DATA_W/8-1:0]   ram_wenb_o,
   output logic [ADDR_W-1:0]     ram_addr_o,
   output logic [DATA_W-1:0]     ram_wdata_o,
   input  logic [DATA_W-1:0]     ram_rdata_i
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam logic        MODE   = 1'(ARB_MODE);
   localparam logic [ARB_CNT_W-1:0] LIMIT = ARB_CNT_W'(STARVE_LIMIT);

   logic [1:0]           grant_c;
   logic                 starve_hit_c;
   logic [ARB_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic                 last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic                 m0_rvalid_q, m0_rvalid_d;
   logic                 m1_rvalid_q, m1_rvalid_d;

   assign starve_hit_c = (MODE == ARB_FIXED) && (starve_cnt_q == LIMIT);

   spram_arb_pick u_pick (
      .valid_i      ({m1_valid_i, m0_valid_i}),
      .mode_i       (MODE),
      .last_grant_i (last_grant_q),
      .starve_hit_i (starve_hit_c),
      .grant_c      (grant_c)
   );

   assign m0_ready_o  = grant_c[0];
   assign m1_ready_o  = grant_c[1];
   assign m0_rvalid_o = m0_rvalid_q;
   assign m1_rvalid_o = m1_rvalid_q;
   assign m0_rdata_o  = ram_rdata_i;
   assign m1_rdata_o  = ram_rdata_i;

   // Output mux; address/wdata hold their last value when idle to avoid toggling the macro.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      m0_rvalid_d  = 1'b0;
      m1_rvalid_d  = 1'b0;
      ram_wenb_o   = '1;

      if (grant_c[0]) begin
         addr_d       = m0_addr_i;
         wdata_d      = m0_wdata_i;
         ram_wenb_o   = ~m0_wstrb_i;
         last_grant_d = ARB_M0;
         m0_rvalid_d  = (m0_wstrb_i == STRB_W'(0));
      end else if (grant_c[1]) begin
         addr_d       = m1_addr_i;
         wdata_d      = m1_wdata_i;
         ram_wenb_o   = ~m1_wstrb_i;
         last_grant_d = ARB_M1;
         m1_rvalid_d  = (m1_wstrb_i == STRB_W'(0));
      end

      ram_addr_o  = addr_d;
      ram_wdata_o = wdata_d;

      if (MODE == ARB_FIXED) begin
         if (!m1_valid_i || grant_c[1]) begin
            starve_cnt_d = '0;
         end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + ARB_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         starve_cnt_q <= '0;
         last_grant_q <= ARB_M1;
         addr_q       <= '0;
         wdata_q      <= '0;
         m0_rvalid_q  <= 1'b0;
         m1_rvalid_q  <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         m0_rvalid_q  <= m0_rvalid_d;
         m1_rvalid_q  <= m1_rvalid_d;
      end
   end

endmodule
